wb_frame_fetch: RTL and testbench

Wishbone classic master that reads a block of 32-bit words from a Wishbone slave (the wb_bram frame/program memory) and streams them out over a valid/ready interface.
- Software or a controller supplies a base address and a length, then pulses start.
- The block fetches the words sequentially into a small FIFO and presents them to a downstream consumer (e.g. LED/pixel shifter).
- It raises done once the last word has been accepted downstream.

---
 rtl/wb_fetch_pkg.sv | 25 ++
 rtl/wb_frame_fetch_sync_fifo.sv | 68 ++++++
 rtl/wb_frame_fetch.sv | 183 ++++++++++++++++++
 tb/tb_wb_frame_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_fetch_pkg.sv
// ============================================================================
// Module : wb_fetch_pkg
// Purpose: Shared types and constants for the Wishbone frame fetcher.
//          - state_t     : fetch FSM state encoding
//          - WB_SEL_ALL  : byte-select for full 32-bit reads
//          - WORD_STRIDE : byte increment between consecutive words
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
   localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

`default_nettype wire

// File: rtl/wb_frame_fetch_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Purpose: Single-clock first-word-fall-through FIFO. The head word is shown
//          on dout whenever empty is low.
// Ports  : clk_i, rst_ni     clock / asynchronous active-low reset
//          push, din         write request and data (ignored when full
//                            unless a pop happens in the same cycle)
//          pop               read request (ignored when empty)
//          dout              head word
//          empty, full       occupancy flags
//          count             current number of stored words (0..2**aw)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int width = 32,
   parameter int aw    = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [aw:0]      count
);

   localparam int depth = 1 << aw;

   logic [width-1:0] mem [depth];
   logic [aw-1:0]    rd_ptr;
   logic [aw-1:0]    wr_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == (aw+1)'(depth));
   // A push into a full FIFO is legal only when the head leaves that cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + aw'(1);
         if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (aw+1)'(1);
            2'b01:   count <= count - (aw+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/wb_frame_fetch.sv
// ============================================================================
// Module : wb_frame_fetch
// Purpose: Wishbone classic read master. Fetches len_i consecutive 32-bit
//          words starting at base_adr_i into a small FIFO and streams them
//          out over valid/ready. done_o pulses once the last word has been
//          accepted downstream.
// Ports  : clk_i, rst_ni              clock / async active-low reset
//          start_i, base_adr_i, len_i transfer request (sampled in IDLE)
//          busy_o, done_o             transfer status
//          wb_*                       Wishbone classic master port
//          st_dat_o, st_valid_o,
//          st_ready_i                 output stream
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_frame_fetch
   import wb_fetch_pkg::*;
#(
   parameter int fifo_aw   = 3,
   parameter int len_width = 11
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [31:0]          base_adr_i,
   input  logic [len_width-1:0] len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [31:0]          wb_adr_o,
   output logic [3:0]           wb_sel_o,
   input  logic [31:0]          wb_dat_i,
   input  logic                 wb_ack_i,
   output logic [31:0]          st_dat_o,
   output logic                 st_valid_o,
   input  logic                 st_ready_i
);

   localparam int depth = 1 << fifo_aw;

   state_t               state,     state_next;
   logic [31:0]          adr,       adr_next;
   logic [len_width-1:0] remaining, remaining_next;
   logic                 cyc,       cyc_next;
   logic                 stb,       stb_next;
   logic                 busy,      busy_next;
   logic                 done,      done_next;

   logic                 push;
   logic                 pop;
   logic                 empty;
   logic                 full;
   logic [fifo_aw:0]     count;
   logic [fifo_aw:0]     count_after;

   // An ack only counts while our strobe is up; stray acks are dropped.
   assign push = stb & wb_ack_i;
   assign pop  = st_valid_o & st_ready_i;

   // Occupancy after this cycle's push/pop; decides whether the strobe may
   // stay up for the next word without risking an overflow.
   assign count_after = count + {{fifo_aw{1'b0}}, push} - {{fifo_aw{1'b0}}, pop};

   sync_fifo #(
      .width (32),
      .aw    (fifo_aw)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (push),
      .pop    (pop),
      .din    (wb_dat_i),
      .dout   (st_dat_o),
      .empty  (empty),
      .full   (full),
      .count  (count)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ST_IDLE;
         adr       <= '0;
         remaining <= '0;
         cyc       <= 1'b0;
         stb       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         adr       <= adr_next;
         remaining <= remaining_next;
         cyc       <= cyc_next;
         stb       <= stb_next;
         busy      <= busy_next;
         done      <= done_next;
      end
   end

   always_comb begin
      state_next     = state;
      adr_next       = adr;
      remaining_next = remaining;
      cyc_next       = cyc;
      stb_next       = stb;
      busy_next      = busy;
      done_next      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  adr_next       = base_adr_i & ~32'h3;
                  remaining_next = len_i;
                  busy_next      = 1'b1;
                  if (!full) begin
                     state_next = ST_REQ;
                     cyc_next   = 1'b1;
                     stb_next   = 1'b1;
                  end else begin
                     state_next = ST_HOLD;
                  end
               end else begin
                  done_next = 1'b1;
               end
            end
         end

         ST_REQ: begin
            if (wb_ack_i) begin
               remaining_next = remaining - len_width'(1);
               adr_next       = adr + WORD_STRIDE;
               if (remaining == len_width'(1)) begin
                  state_next = ST_DRAIN;
                  cyc_next   = 1'b0;
                  stb_next   = 1'b0;
               end else if (count_after >= (fifo_aw+1)'(depth)) begin
                  state_next = ST_HOLD;
                  cyc_next   = 1'b0;
                  stb_next   = 1'b0;
               end
            end
         end

         ST_HOLD: begin
            if (!full) begin
               state_next = ST_REQ;
               cyc_next   = 1'b1;
               stb_next   = 1'b1;
            end
         end

         ST_DRAIN: begin
            if (count_after == '0) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
               busy_next  = 1'b0;
            end
         end

         default: begin
            state_next = ST_IDLE;
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign busy_o     = busy;
   assign done_o     = done;
   assign wb_cyc_o   = cyc;
   assign wb_stb_o   = stb;
   assign wb_adr_o   = adr;
   assign wb_we_o    = 1'b0;
   assign wb_sel_o   = WB_SEL_ALL;
   assign st_valid_o = ~empty;

endmodule

`default_nettype wire

// File: tb/tb_wb_frame_fetch.sv
// ============================================================================
// Module : tb_wb_frame_fetch
// Purpose: Self-checking bench for wb_frame_fetch with a wb_bram-like slave
//          (word i holds 0x100+i, ack one cycle after strobe).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_frame_fetch;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [31:0] base_adr_i;
   logic [10:0] len_i;
   logic        busy_o;
   logic        done_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic [31:0] st_dat_o;
   logic        st_valid_o;
   logic        st_ready_i = 1'b0;

   logic        ready_lvl = 1'b0;
   logic        rand_en   = 1'b0;

   int          n_chk  = 0;
   int          n_fail = 0;

   logic [31:0] adr_q [$];
   logic [31:0] dat_q [$];
   int          ack_cnt   = 0;
   int          done_cnt  = 0;
   int          ovf_cnt   = 0;
   int          occ       = 0;
   logic        cyc_seen  = 1'b0;
   logic        busy_seen = 1'b0;

   always #5 clk_i = ~clk_i;

   wb_frame_fetch dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .base_adr_i (base_adr_i),
      .len_i      (len_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_adr_o   (wb_adr_o),
      .wb_sel_o   (wb_sel_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i),
      .st_dat_o   (st_dat_o),
      .st_valid_o (st_valid_o),
      .st_ready_i (st_ready_i)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h100 + {2'b00, a[31:2]};
   endfunction

   // wb_bram-like slave: registered ack and data, one word every 2 cycles.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_ack_i <= 1'b0;
         wb_dat_i <= '0;
      end else begin
         wb_ack_i <= wb_cyc_o & wb_stb_o & ~wb_ack_i;
         wb_dat_i <= mem_word(wb_adr_o);
      end
   end

   always @(posedge clk_i) begin
      #1;
      st_ready_i = rand_en ? 1'($urandom_range(0, 1)) : ready_lvl;
   end

   // Bus/stream monitor, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         occ = 0;
      end else begin
         if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            adr_q.push_back(wb_adr_o);
            ack_cnt++;
            occ++;
         end
         if (st_valid_o && st_ready_i) begin
            dat_q.push_back(st_dat_o);
            occ--;
         end
         if (occ > 8) ovf_cnt++;
         if (done_o)   done_cnt++;
         if (wb_cyc_o) cyc_seen = 1'b1;
         if (busy_o)   busy_seen = 1'b1;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      adr_q.delete();
      dat_q.delete();
      ack_cnt   = 0;
      done_cnt  = 0;
      ovf_cnt   = 0;
      cyc_seen  = 1'b0;
      busy_seen = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic do_start(input logic [31:0] b, input logic [10:0] l);
      @(posedge clk_i);
      #1;
      start_i    = 1'b1;
      base_adr_i = b;
      len_i      = l;
      @(posedge clk_i);
      #1;
      start_i    = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int k;
      k = 0;
      while (done_cnt < target && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      check("done_timeout", 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic check_stream(input string nm, input logic [31:0] b, input int n);
      logic [31:0] a;
      check({nm, "_nwords"}, 32'(dat_q.size()), 32'(n));
      check({nm, "_nacks"}, 32'(ack_cnt), 32'(n));
      for (int i = 0; i < n; i++) begin
         a = (b & 32'hFFFF_FFFC) + 32'(4 * i);
         if (i < adr_q.size()) check({nm, "_adr"}, adr_q[i], a);
         if (i < dat_q.size()) check({nm, "_dat"}, dat_q[i], mem_word(a));
      end
   endtask

   typedef struct {
      logic [31:0] base;
      logic [10:0] len;
      logic [31:0] first_dat;
      logic [31:0] last_adr;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   k;

      vecs[0] = '{base: 32'h0000_0000, len: 11'd4, first_dat: 32'h100,        last_adr: 32'h0000_000C};
      vecs[1] = '{base: 32'h0000_0000, len: 11'd0, first_dat: 32'h0,          last_adr: 32'h0};
      vecs[2] = '{base: 32'hFFFF_FFF8, len: 11'd3, first_dat: 32'h4000_00FE,   last_adr: 32'h0000_0000};
      vecs[3] = '{base: 32'h0000_0013, len: 11'd2, first_dat: 32'h104,        last_adr: 32'h0000_0014};

      rst_ni     = 1'b0;
      start_i    = 1'b0;
      base_adr_i = '0;
      len_i      = '0;
      tick(3);

      // Reset state
      check("rst_cyc",   32'(wb_cyc_o),   32'd0);
      check("rst_stb",   32'(wb_stb_o),   32'd0);
      check("rst_adr",   wb_adr_o,        32'd0);
      check("rst_busy",  32'(busy_o),     32'd0);
      check("rst_done",  32'(done_o),     32'd0);
      check("rst_valid", 32'(st_valid_o), 32'd0);
      check("rst_we",    32'(wb_we_o),    32'd0);
      check("rst_sel",   32'(wb_sel_o),   32'hF);
      rst_ni = 1'b1;
      tick(2);

      // Table-driven transfers with ready held high
      ready_lvl = 1'b1;
      for (int t = 0; t < 4; t++) begin
         v = vecs[t];
         clear_mon();
         do_start(v.base, v.len);
         @(negedge clk_i);
         if (v.len == 0) begin
            check("len0_done_next", 32'(done_o), 32'd1);
            check("len0_busy", 32'(busy_o), 32'd0);
         end else begin
            check("busy_after_start", 32'(busy_o), 32'd1);
         end
         wait_done(1, 400);
         tick(5);
         check("vec_done_once", 32'(done_cnt), 32'd1);
         check("vec_busy_after", 32'(busy_o), 32'd0);
         check("vec_cyc_after", 32'(wb_cyc_o), 32'd0);
         check("vec_ovf", 32'(ovf_cnt), 32'd0);
         check_stream("vec", v.base, int'(v.len));
         if (v.len == 0) begin
            check("len0_cyc_seen", 32'(cyc_seen), 32'd0);
            check("len0_busy_seen", 32'(busy_seen), 32'd0);
         end else begin
            if (dat_q.size() > 0) check("vec_first_dat", dat_q[0], v.first_dat);
            if (adr_q.size() > 0) check("vec_last_adr", adr_q[adr_q.size()-1], v.last_adr);
         end
      end

      // Backpressure: FIFO fills to 8 and the bus is released
      clear_mon();
      ready_lvl = 1'b0;
      do_start(32'h0, 11'd20);
      tick(60);
      @(negedge clk_i);
      check("bp_acks", 32'(ack_cnt), 32'd8);
      check("bp_cyc_hold", 32'(wb_cyc_o), 32'd0);
      check("bp_busy", 32'(busy_o), 32'd1);
      check("bp_head", st_dat_o, 32'h100);
      ready_lvl = 1'b1;
      wait_done(1, 400);
      tick(5);
      check("bp_done_once", 32'(done_cnt), 32'd1);
      check("bp_ovf", 32'(ovf_cnt), 32'd0);
      check_stream("bp", 32'h0, 20);

      // Reset in the middle of a transfer
      clear_mon();
      do_start(32'h0, 11'd10);
      k = 0;
      while (ack_cnt < 2 && k < 100) begin
         @(negedge clk_i);
         k++;
      end
      check("mr_reach_ack2", 32'(ack_cnt >= 2), 32'd1);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      check("mr_cyc_async",   32'(wb_cyc_o),   32'd0);
      check("mr_stb_async",   32'(wb_stb_o),   32'd0);
      check("mr_valid_async", 32'(st_valid_o), 32'd0);
      check("mr_busy_async",  32'(busy_o),     32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      tick(30);
      check("mr_no_done", 32'(done_cnt), 32'd0);
      clear_mon();
      do_start(32'h40, 11'd3);
      wait_done(1, 400);
      tick(5);
      check("mr_restart_done", 32'(done_cnt), 32'd1);
      check_stream("mr", 32'h40, 3);

      // Random backpressure with a second start while busy
      clear_mon();
      rand_en = 1'b1;
      do_start(32'h80, 11'd16);
      tick(6);
      do_start(32'h200, 11'd5);
      wait_done(1, 2000);
      tick(40);
      rand_en = 1'b0;
      tick(2);
      check("rnd_done_once", 32'(done_cnt), 32'd1);
      check("rnd_ovf", 32'(ovf_cnt), 32'd0);
      check("rnd_busy_after", 32'(busy_o), 32'd0);
      check_stream("rnd", 32'h80, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
